// File: rtl/set_assoc_cache.sv
// N-way set-associative write-back cache with true-LRU replacement.
// CPU line port (mem_*) in front, physical-memory line port (pmem_*) behind.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   mem_read/mem_write    CPU line request, held until mem_resp (write wins)
//   mem_address           byte address, offset bits ignored
//   mem_byte_enable       per-byte write mask
//   mem_wdata/mem_rdata   write line / read line (valid with mem_resp)
//   mem_resp              one-cycle completion pulse
//   pmem_read/pmem_write  line fill / writeback request
//   pmem_address          line-aligned physical address
//   pmem_wdata/pmem_rdata writeback line / fill line
//   pmem_resp             one-cycle completion of a pmem request
module set_assoc_cache #(
    parameter int NUM_WAYS   = 4,
    parameter int NUM_SETS   = 8,
    parameter int LINE_BYTES = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    mem_read,
    input  logic                    mem_write,
    input  logic [31:0]             mem_address,
    input  logic [LINE_BYTES-1:0]   mem_byte_enable,
    input  logic [8*LINE_BYTES-1:0] mem_wdata,
    output logic [8*LINE_BYTES-1:0] mem_rdata,
    output logic                    mem_resp,
    output logic                    pmem_read,
    output logic                    pmem_write,
    output logic [31:0]             pmem_address,
    output logic [8*LINE_BYTES-1:0] pmem_wdata,
    input  logic [8*LINE_BYTES-1:0] pmem_rdata,
    input  logic                    pmem_resp
);

    localparam int OFFSET_BITS = $clog2(LINE_BYTES);
    localparam int INDEX_BITS  = $clog2(NUM_SETS);
    localparam int TAG_BITS    = 32 - INDEX_BITS - OFFSET_BITS;
    localparam int WAY_BITS    = $clog2(NUM_WAYS);
    localparam int LINE_W      = 8 * LINE_BYTES;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        WRITEBACK,
        FILL
    } state_e;

    state_e state_q, state_d;
    logic [WAY_BITS-1:0] victim_q, victim_d;

    logic [TAG_BITS-1:0] tag_q   [NUM_WAYS][NUM_SETS];
    logic [LINE_W-1:0]   data_q  [NUM_WAYS][NUM_SETS];
    logic                valid_q [NUM_WAYS][NUM_SETS];
    logic                dirty_q [NUM_WAYS][NUM_SETS];
    logic [WAY_BITS-1:0] age_q   [NUM_WAYS][NUM_SETS];

    logic [INDEX_BITS-1:0] idx;
    logic [TAG_BITS-1:0]   req_tag;
    logic                  req;
    logic                  is_write;
    logic                  unused_offset;

    assign idx           = mem_address[OFFSET_BITS +: INDEX_BITS];
    assign req_tag       = mem_address[31 -: TAG_BITS];
    assign req           = mem_read | mem_write;
    assign is_write      = mem_write;
    assign unused_offset = ^mem_address[OFFSET_BITS-1:0];

    logic                hit;
    logic [WAY_BITS-1:0] hit_way;
    logic [WAY_BITS-1:0] hit_age;
    logic [WAY_BITS-1:0] victim_sel;
    logic                found_inv;
    logic [LINE_W-1:0]   merged;
    logic                hit_upd;
    logic                wb_done;
    logic                fill_done;

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (!hit && valid_q[w][idx] && tag_q[w][idx] == req_tag) begin
                hit     = 1'b1;
                hit_way = WAY_BITS'(w);
            end
        end
    end

    assign hit_age = age_q[hit_way][idx];

    // Victim: first empty way, otherwise the oldest (age NUM_WAYS-1).
    always_comb begin
        found_inv  = 1'b0;
        victim_sel = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (!found_inv && !valid_q[w][idx]) begin
                found_inv  = 1'b1;
                victim_sel = WAY_BITS'(w);
            end
        end
        if (!found_inv) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                if (age_q[w][idx] == WAY_BITS'(NUM_WAYS - 1)) begin
                    victim_sel = WAY_BITS'(w);
                end
            end
        end
    end

    always_comb begin
        merged = data_q[hit_way][idx];
        for (int b = 0; b < LINE_BYTES; b++) begin
            if (mem_byte_enable[b]) begin
                merged[8*b +: 8] = mem_wdata[8*b +: 8];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        victim_d     = victim_q;
        mem_resp     = 1'b0;
        mem_rdata    = '0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        hit_upd      = 1'b0;
        wb_done      = 1'b0;
        fill_done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req) state_d = CHECK;
            end
            CHECK: begin
                if (!req) begin
                    state_d = IDLE;
                end else if (hit) begin
                    mem_resp = 1'b1;
                    hit_upd  = 1'b1;
                    if (!is_write) mem_rdata = data_q[hit_way][idx];
                    state_d = IDLE;
                end else begin
                    victim_d = victim_sel;
                    if (valid_q[victim_sel][idx] && dirty_q[victim_sel][idx])
                        state_d = WRITEBACK;
                    else
                        state_d = FILL;
                end
            end
            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {tag_q[victim_q][idx], idx, {OFFSET_BITS{1'b0}}};
                pmem_wdata   = data_q[victim_q][idx];
                if (pmem_resp) begin
                    wb_done = 1'b1;
                    state_d = FILL;
                end
            end
            FILL: begin
                pmem_read    = 1'b1;
                pmem_address = {req_tag, idx, {OFFSET_BITS{1'b0}}};
                if (pmem_resp) begin
                    fill_done = 1'b1;
                    state_d   = CHECK;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state and metadata; ages reset to a per-set permutation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            victim_q <= '0;
            for (int w = 0; w < NUM_WAYS; w++) begin
                for (int s = 0; s < NUM_SETS; s++) begin
                    valid_q[w][s] <= 1'b0;
                    dirty_q[w][s] <= 1'b0;
                    age_q[w][s]   <= WAY_BITS'(w);
                end
            end
        end else begin
            state_q  <= state_d;
            victim_q <= victim_d;
            if (hit_upd) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    if (WAY_BITS'(w) == hit_way)
                        age_q[w][idx] <= '0;
                    else if (age_q[w][idx] < hit_age)
                        age_q[w][idx] <= age_q[w][idx] + WAY_BITS'(1);
                end
                if (is_write) dirty_q[hit_way][idx] <= 1'b1;
            end
            if (wb_done) dirty_q[victim_q][idx] <= 1'b0;
            if (fill_done) begin
                valid_q[victim_q][idx] <= 1'b1;
                dirty_q[victim_q][idx] <= 1'b0;
            end
        end
    end

    // Tag and data storage carry no reset; valid bits gate their use.
    always_ff @(posedge clk) begin
        if (hit_upd && is_write) data_q[hit_way][idx] <= merged;
        if (fill_done) begin
            data_q[victim_q][idx] <= pmem_rdata;
            tag_q[victim_q][idx]  <= req_tag;
        end
    end

endmodule

// File: tb/tb_set_assoc_cache.sv
// Directed bench for set_assoc_cache: scoreboarded CPU reads and pmem
// transactions against a reactive backing-store model.
module tb_set_assoc_cache;

    localparam int LB = 32;
    localparam int LW = 8 * LB;

    logic          clk;
    logic          rst_n;
    logic          mem_read;
    logic          mem_write;
    logic [31:0]   mem_address;
    logic [LB-1:0] mem_byte_enable;
    logic [LW-1:0] mem_wdata;
    logic [LW-1:0] mem_rdata;
    logic          mem_resp;
    logic          pmem_read;
    logic          pmem_write;
    logic [31:0]   pmem_address;
    logic [LW-1:0] pmem_wdata;
    logic [LW-1:0] pmem_rdata;
    logic          pmem_resp;

    set_assoc_cache #(
        .NUM_WAYS  (4),
        .NUM_SETS  (8),
        .LINE_BYTES(LB)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_byte_enable(mem_byte_enable),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_resp       (mem_resp),
        .pmem_read      (pmem_read),
        .pmem_write     (pmem_write),
        .pmem_address   (pmem_address),
        .pmem_wdata     (pmem_wdata),
        .pmem_rdata     (pmem_rdata),
        .pmem_resp      (pmem_resp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic          wr;
        logic [31:0]   addr;
        logic [LW-1:0] wd;
    } pm_t;

    int            tests = 0;
    int            fails = 0;
    int            pmem_delay = 2;
    pm_t           pm_q[$];
    logic [LW-1:0] rd_q[$];
    logic [LW-1:0] cpu_mem[bit [31:0]];
    logic [LW-1:0] bstore[bit [31:0]];

    task automatic chk(input string tag, input logic [LW-1:0] obs,
                       input logic [LW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [LW-1:0] pat(input logic [31:0] a);
        logic [LW-1:0] l;
        for (int k = 0; k < LW / 32; k++)
            l[32*k +: 32] = a ^ (32'(k) * 32'h0101_0100) ^ 32'h0000_00A5;
        return l;
    endfunction

    function automatic logic [31:0] la(input logic [31:0] a);
        return {a[31:5], 5'b0};
    endfunction

    function automatic logic [LW-1:0] cpu_get(input logic [31:0] a);
        if (cpu_mem.exists(la(a))) return cpu_mem[la(a)];
        return pat(la(a));
    endfunction

    function automatic logic [LW-1:0] bs_get(input logic [31:0] a);
        if (bstore.exists(a)) return bstore[a];
        return pat(a);
    endfunction

    task automatic push_pm(input logic wr, input logic [31:0] a,
                           input logic [LW-1:0] wd);
        pm_t e;
        e.wr   = wr;
        e.addr = a;
        e.wd   = wd;
        pm_q.push_back(e);
    endtask

    // Physical memory: answers after pmem_delay extra cycles and checks
    // each new request against the expected pmem transaction queue.
    initial begin : pmem_model
        bit            busy;
        int            cnt;
        pm_t           cur;
        pm_t           e;
        busy       = 1'b0;
        cnt        = 0;
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        cur        = '0;
        forever begin
            @(negedge clk);
            pmem_resp = 1'b0;
            if (!rst_n) begin
                busy = 1'b0;
            end else if (pmem_read || pmem_write) begin
                chk("pmem_rw_excl", pmem_read & pmem_write, 1'b0);
                chk("mem_resp_in_pmem", mem_resp, 1'b0);
                if (!busy) begin
                    busy     = 1'b1;
                    cnt      = 0;
                    cur.wr   = pmem_write;
                    cur.addr = pmem_address;
                    cur.wd   = pmem_wdata;
                    tests++;
                    assert (pm_q.size() != 0) else begin
                        fails++;
                        $error("FAIL pmem_unexpected: got wr=%0b addr %0h expected none",
                               pmem_write, pmem_address);
                    end
                    if (pm_q.size() != 0) begin
                        e = pm_q.pop_front();
                        chk("pmem_kind", pmem_write, e.wr);
                        chk("pmem_addr", pmem_address, e.addr);
                        if (e.wr) chk("pmem_wdata", pmem_wdata, e.wd);
                    end
                end else begin
                    chk("pmem_kind_stable", pmem_write, cur.wr);
                    chk("pmem_addr_stable", pmem_address, cur.addr);
                    chk("pmem_wdata_stable", pmem_wdata, cur.wd);
                end
                if (cnt == pmem_delay) begin
                    pmem_resp = 1'b1;
                    if (pmem_write) bstore[pmem_address] = pmem_wdata;
                    else pmem_rdata = bs_get(pmem_address);
                    busy = 1'b0;
                end
                cnt++;
            end
        end
    end

    task automatic req(input string tag, input logic wr, input logic [31:0] a,
                       input logic [LB-1:0] be, input logic [LW-1:0] wd,
                       input int exp_lat);
        logic [LW-1:0] line;
        logic [LW-1:0] exp_rd;
        int            lat;
        bit            got;
        line = cpu_get(a);
        if (wr) begin
            for (int b = 0; b < LB; b++)
                if (be[b]) line[8*b +: 8] = wd[8*b +: 8];
            cpu_mem[la(a)] = line;
        end else begin
            rd_q.push_back(line);
        end
        mem_read        = !wr;
        mem_write       = wr;
        mem_address     = a;
        mem_byte_enable = be;
        mem_wdata       = wd;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 300) begin
            @(negedge clk);
            lat++;
            if (mem_resp === 1'b1) got = 1'b1;
        end
        chk({tag, "_resp"}, got, 1'b1);
        if (!wr && rd_q.size() != 0) begin
            exp_rd = rd_q.pop_front();
            if (got) chk({tag, "_rdata"}, mem_rdata, exp_rd);
        end
        if (got) chk({tag, "_lat"}, lat, exp_lat);
        @(negedge clk);
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    function automatic logic [LW-1:0] rnd_line();
        logic [LW-1:0] l;
        for (int k = 0; k < LW / 32; k++) l[32*k +: 32] = $urandom;
        return l;
    endfunction

    initial begin : watchdog
        #200000;
        fails++;
        $display("FAIL watchdog: got timeout expected $finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [LW-1:0] wd;
        int            d;
        rst_n           = 1'b0;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_address     = '0;
        mem_byte_enable = '0;
        mem_wdata       = '0;
        repeat (3) @(negedge clk);
        chk("rst_mem_resp", mem_resp, 1'b0);
        chk("rst_pmem_read", pmem_read, 1'b0);
        chk("rst_pmem_write", pmem_write, 1'b0);
        chk("rst_pmem_addr", pmem_address, 32'h0);
        chk("rst_mem_rdata", mem_rdata, '0);
        chk("rst_pmem_wdata", pmem_wdata, '0);
        rst_n = 1'b1;
        @(negedge clk);
        d = pmem_delay;

        // cold miss, then hit
        push_pm(1'b0, 32'h0000_1000, '0);
        req("cold_rd", 1'b0, 32'h0000_1000, '0, '0, d + 3);
        req("hit_rd", 1'b0, 32'h0000_1000, '0, '0, 1);

        // partial write hit, read back merged
        wd = rnd_line();
        wd[31:0] = 32'hDEAD_BEEF;
        req("wr_hit", 1'b1, 32'h0000_1000, 32'h0000_000F, wd, 1);
        req("rd_merged", 1'b0, 32'h0000_1000, '0, '0, 1);

        // fill the rest of set 0
        push_pm(1'b0, 32'h0000_2000, '0);
        req("fill_2000", 1'b0, 32'h0000_2000, '0, '0, d + 3);
        push_pm(1'b0, 32'h0000_3000, '0);
        req("fill_3000", 1'b0, 32'h0000_3000, '0, '0, d + 3);
        push_pm(1'b0, 32'h0000_4000, '0);
        req("fill_4000", 1'b0, 32'h0000_4000, '0, '0, d + 3);
        req("touch_1000", 1'b0, 32'h0000_1000, '0, '0, 1);

        // LRU victim is 0x2000 (clean)
        push_pm(1'b0, 32'h0000_5000, '0);
        req("evict_2000", 1'b0, 32'h0000_5000, '0, '0, d + 3);
        req("hit_3000", 1'b0, 32'h0000_3000, '0, '0, 1);
        req("hit_4000", 1'b0, 32'h0000_4000, '0, '0, 1);
        req("hit_5000", 1'b0, 32'h0000_5000, '0, '0, 1);

        // dirty 0x1000 is now LRU: writeback then fill, slow memory
        pmem_delay = 10;
        d = pmem_delay;
        push_pm(1'b1, 32'h0000_1000, cpu_get(32'h0000_1000));
        push_pm(1'b0, 32'h0000_6000, '0);
        req("dirty_miss", 1'b0, 32'h0000_6000, '0, '0, 2 * d + 4);

        // written-back data comes back from memory
        pmem_delay = 2;
        d = pmem_delay;
        push_pm(1'b0, 32'h0000_1000, '0);
        req("refill_1000", 1'b0, 32'h0000_1000, '0, '0, d + 3);

        // write miss in set 1 allocates, then merges
        wd = rnd_line();
        push_pm(1'b0, 32'h0000_1020, '0);
        req("wr_miss", 1'b1, 32'h0000_1020, 32'hF0F0_0F01, wd, d + 3);
        req("rd_1020", 1'b0, 32'h0000_1020, '0, '0, 1);

        // reset while a fill is outstanding
        pmem_delay = 20;
        push_pm(1'b0, 32'h0000_7000, '0);
        mem_read    = 1'b1;
        mem_address = 32'h0000_7000;
        repeat (5) @(negedge clk);
        chk("fill_pending", pmem_read, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_pmem_read", pmem_read, 1'b0);
        chk("rst_async_pmem_write", pmem_write, 1'b0);
        chk("rst_async_pmem_addr", pmem_address, 32'h0);
        mem_read = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // all lines invalid after reset
        pmem_delay = 2;
        d = pmem_delay;
        push_pm(1'b0, 32'h0000_1000, '0);
        req("post_rst_miss", 1'b0, 32'h0000_1000, '0, '0, d + 3);

        repeat (3) @(negedge clk);
        chk("pmem_q_drained", pm_q.size(), 0);
        chk("rd_q_drained", rd_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
